maquina_estado_divisor: RTL and testbench
=========================================

# maquina_estado_divisor

Sequential unsigned divider by repeated subtraction, the inverse of the team's repeated-addition summing FSM. It uses the same `inicio`/`pronto` start/done handshake, so both blocks can sit side by side on the datapath and be driven by the same controller. On an accepted start it samples a dividend and divisor, subtracts the divisor until the remainder is smaller than it, and presents quotient, remainder and a divide-by-zero flag.

## Interface
Parameters:
- `WIDTH`, default 6: width of dividend, divisor, quotient and remainder.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `inicio`  in  1  start request; sampled only in IDLE.
- `dividendo`  in  WIDTH  unsigned dividend; sampled at start acceptance only.
- `divisor`  in  WIDTH  unsigned divisor; sampled at start acceptance only.
- `pronto`  out  1  ready/done; 1 in IDLE and DONE, 0 in CHECK and SUB.
- `div_zero`  out  1  last accepted operation had divisor 0.
- `quociente`  out  WIDTH  quotient register.
- `resto`  out  WIDTH  remainder register.

## Operation
- FSM states: IDLE, CHECK, SUB, DONE (2-bit encoding).
- IDLE, `inicio`=1: load `resto` from `dividendo`; load the internal `div_reg` from `divisor`; clear `quociente` and `div_zero`; go to CHECK.
- IDLE, `inicio`=0: stay in IDLE. All registers hold.
- CHECK with `div_reg`=0: set `div_zero`=1 and `quociente`=all ones (2^WIDTH-1); `resto` keeps the dividend; go to DONE.
- CHECK with `resto` >= `div_reg`: go to SUB.
- CHECK otherwise: go to DONE.
- SUB: `resto` <= `resto` - `div_reg`; `quociente` <= `quociente` + 1; go to CHECK.
- DONE: go to IDLE unconditionally. `inicio` is ignored in DONE.
- Arithmetic rules:
  - The comparison is unsigned WIDTH-bit, taken as the borrow of `resto` - `div_reg`.
  - The subtraction never underflows.
  - `quociente` never exceeds 2^WIDTH-1, which is reached only for divisor 1 with dividend all ones. No wrap occurs.
- `inicio` is ignored in CHECK, SUB and DONE. No queuing.
- Changes on `dividendo`/`divisor` after acceptance have no effect.
- `quociente`, `resto` and `div_zero` are valid only while `pronto`=1. They hold stable from DONE through IDLE until the next accepted start.
- While busy (CHECK/SUB), the outputs show intermediate values. Consumers must ignore them.

## Timing
- Reset values: state IDLE, `pronto`=1, `div_zero`=0, `quociente`=0, `resto`=0, `div_reg`=0.
- Let E0 be the clock edge that accepts the start and Q the final quotient.
- DONE is entered at edge E0+2Q+1. `pronto` rises after that edge.
- Divide by zero: DONE is entered at E0+1.
- Worst case (all ones / 1, WIDTH=6): 127 cycles busy.
- The earliest next start is accepted at DONE+1, in IDLE. With `inicio` held high, consecutive operations are separated by exactly one DONE cycle plus one IDLE cycle.
- Reset asserted mid-operation aborts immediately (asynchronous). All outputs take their reset values; no partial result is retained.
- Reset released while `inicio`=1: the start is accepted on the first rising edge after release.
- `pronto` is a Moore output decoded from the state register. No combinational path exists from inputs to outputs.

## Structure
- Shared package contains:
  - state encoding constants IDLE=0, CHECK=1, SUB=2, DONE=3;
  - the default WIDTH.
- The summing FSM also imports this package.
- One combinational sub-module, `subtrator_borrow`:
  - inputs `a`, `b` (WIDTH);
  - outputs `diff` (WIDTH) and `borrow` (1).
- `borrow`=0 drives the CHECK decision, and `diff` drives the SUB update, so one subtractor serves both.
- The FSM and registers live in the top module.

## Test plan
- 13/4 -> `quociente`=3, `resto`=1, `div_zero`=0. `pronto` rises 7 cycles after the accepting edge. Outputs hold until the next start.
- 3/5 -> Q=0, R=3 after 1 cycle. Then 0/7 -> Q=0, R=0 after 1 cycle.
- 63/1 (WIDTH=6) -> Q=63, R=0 after 127 cycles. `pronto` stays 0 for the entire busy period.
- 9/0 -> `div_zero`=1, Q=63, R=9 after 1 cycle. Then 6/3 -> `div_zero`=0, Q=2, R=0.
- 40/3 started, then:
  - toggling `inicio`, `dividendo` and `divisor` while busy -> the result is still Q=13, R=1;
  - a separate run with reset pulsed at cycle 10 -> immediately `pronto`=1, Q=0, R=0, `div_zero`=0, and FSM in IDLE.
- `inicio` held high through 8/2 and 7/7 back-to-back -> Q=4/R=0, then Q=1/R=0. The second start is accepted exactly 2 edges after the first DONE is entered.

Source files
------------

// File: rtl/maquina_estado_divisor_pkg.sv
// -----------------------------------------------------------------------------
// maquina_estado_divisor_pkg
//
// Purpose : Shared definitions for the repeated-subtraction divider and its
//           sibling repeated-addition summing FSM. Both blocks use the same
//           state encoding so a common controller can decode either one.
//
// Contents:
//   WIDTH_DEFAULT  default operand width of the datapath blocks
//   STATE_BITS     width of the state register
//   estado_t       FSM state encoding (IDLE=0, CHECK=1, SUB=2, DONE=3)
//   is_ready()     helper: 1 for the states in which the block reports ready
// -----------------------------------------------------------------------------
package maquina_estado_divisor_pkg;

   localparam int WIDTH_DEFAULT = 6;
   localparam int STATE_BITS    = 2;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } estado_t;

   // Ready is a pure function of the state: the block accepts work in IDLE
   // and presents a finished result in DONE.
   function automatic logic is_ready(input estado_t st);
      return (st == IDLE) || (st == DONE);
   endfunction

endpackage : maquina_estado_divisor_pkg

// File: rtl/maquina_estado_divisor_subtrator.sv
// -----------------------------------------------------------------------------
// subtrator_borrow
//
// Purpose : Combinational unsigned WIDTH-bit subtractor, diff = a - b, with
//           the final borrow exposed. borrow=0 means a >= b, so the same
//           hardware serves both as comparator and as subtractor.
//
// Ports:
//   a       in   WIDTH  minuend
//   b       in   WIDTH  subtrahend
//   diff    out  WIDTH  a - b modulo 2^WIDTH
//   borrow  out  1      1 when a < b (unsigned)
// -----------------------------------------------------------------------------
module subtrator_borrow
   import maquina_estado_divisor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // Ripple borrow chain: chain[i] is the borrow into bit i.
   logic [WIDTH:0] chain;

   assign chain[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic bit_xor;

         assign bit_xor      = a[gi] ^ b[gi];
         assign diff[gi]     = bit_xor ^ chain[gi];
         // Borrow out when a<b at this bit, or bits equal and a borrow
         // is already propagating from below.
         assign chain[gi+1]  = (~a[gi] & b[gi]) | (~bit_xor & chain[gi]);
      end
   endgenerate

   assign borrow = chain[WIDTH];

endmodule : subtrator_borrow

// File: rtl/maquina_estado_divisor.sv
// -----------------------------------------------------------------------------
// maquina_estado_divisor
//
// Purpose : Sequential unsigned divider by repeated subtraction. A start
//           accepted in IDLE samples dividend and divisor; the FSM then
//           subtracts the divisor from the running remainder until the
//           remainder is smaller than it, counting subtractions in the
//           quotient. Divisor 0 is flagged and yields an all-ones quotient.
//           Shares the inicio/pronto handshake of the summing FSM.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   inicio     in   1      start request, only looked at in IDLE
//   dividendo  in   WIDTH  unsigned dividend, sampled on start acceptance
//   divisor    in   WIDTH  unsigned divisor, sampled on start acceptance
//   pronto     out  1      1 in IDLE and DONE, 0 while busy
//   div_zero   out  1      last accepted operation had divisor 0
//   quociente  out  WIDTH  quotient register
//   resto      out  WIDTH  remainder register
//
// Latency: DONE is entered 2*Q+1 edges after the accepting edge (Q = final
// quotient), or 1 edge for divisor 0. Results are valid while pronto=1 and
// hold until the next accepted start.
// -----------------------------------------------------------------------------
module maquina_estado_divisor
   import maquina_estado_divisor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   output logic             pronto,
   output logic             div_zero,
   output logic [WIDTH-1:0] quociente,
   output logic [WIDTH-1:0] resto
);

   estado_t          estado;
   logic [WIDTH-1:0] div_reg;

   logic [WIDTH-1:0] sub_diff;
   logic             sub_borrow;
   logic             div_is_zero;

   // One subtractor: its borrow makes the CHECK decision and its difference
   // is the SUB update, so the compare and the subtract always agree.
   subtrator_borrow #(
      .WIDTH (WIDTH)
   ) u_subtrator (
      .a      (resto),
      .b      (div_reg),
      .diff   (sub_diff),
      .borrow (sub_borrow)
   );

   assign div_is_zero = (div_reg == '0);

   // Moore output straight from the state register; no input reaches it.
   assign pronto = is_ready(estado);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado    <= IDLE;
         div_zero  <= 1'b0;
         quociente <= '0;
         resto     <= '0;
         div_reg   <= '0;
      end else begin
         case (estado)
            IDLE: begin
               if (inicio) begin
                  resto     <= dividendo;
                  div_reg   <= divisor;
                  quociente <= '0;
                  div_zero  <= 1'b0;
                  estado    <= CHECK;
               end
            end

            CHECK: begin
               if (div_is_zero) begin
                  // Remainder keeps the dividend; quotient saturates.
                  div_zero  <= 1'b1;
                  quociente <= '1;
                  estado    <= DONE;
               end else if (!sub_borrow) begin
                  estado    <= SUB;
               end else begin
                  estado    <= DONE;
               end
            end

            SUB: begin
               // Only reached with resto >= div_reg, so no underflow, and the
               // count is bounded by dividend/divisor, so no wrap either.
               resto     <= sub_diff;
               quociente <= quociente + WIDTH'(1);
               estado    <= CHECK;
            end

            DONE: begin
               // Results stay put; a held inicio is picked up next in IDLE.
               estado <= IDLE;
            end

            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule : maquina_estado_divisor

// File: tb/tb_maquina_estado_divisor.sv
// -----------------------------------------------------------------------------
// tb_maquina_estado_divisor
//
// Directed bench for the repeated-subtraction divider (WIDTH=6). Inputs are
// driven on the falling edge, outputs sampled on the falling edge. Expected
// quotient/remainder/latency values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_maquina_estado_divisor;
   import maquina_estado_divisor_pkg::*;

   localparam int W     = 6;
   localparam int LIMIT = 400;

   logic         clk;
   logic         reset;
   logic         inicio;
   logic [W-1:0] dividendo;
   logic [W-1:0] divisor;
   logic         pronto;
   logic         div_zero;
   logic [W-1:0] quociente;
   logic [W-1:0] resto;

   int errors;
   int checks;
   int k;
   int lows;

   maquina_estado_divisor #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .inicio    (inicio),
      .dividendo (dividendo),
      .divisor   (divisor),
      .pronto    (pronto),
      .div_zero  (div_zero),
      .quociente (quociente),
      .resto     (resto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present operands at a falling edge, let the next rising edge accept
   // them, and return at the following falling edge (0 edges past accept).
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      @(negedge clk);
      inicio    = 1'b1;
      dividendo = a;
      divisor   = b;
      @(posedge clk);
      @(negedge clk);
      if (!hold) inicio = 1'b0;
   endtask

   // Count rising edges until pronto is seen high; lows counts samples with
   // pronto low. Bounded so a stuck FSM still reaches the summary.
   task automatic wait_done(output int edges, output int low_cnt);
      edges   = 0;
      low_cnt = 0;
      while (pronto !== 1'b1 && edges < LIMIT) begin
         low_cnt++;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("done_within_limit", 32'(pronto), 32'd1);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      inicio    = 1'b0;
      dividendo = '0;
      divisor   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pronto", 32'(pronto), 32'd1);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      chk("rst_q", 32'(quociente), 32'd0);
      chk("rst_r", 32'(resto), 32'd0);
      chk("rst_state", 32'(dut.estado), 32'(IDLE));
      reset = 1'b0;
      $display("step reset: pronto=%0b q=%0d r=%0d", pronto, quociente, resto);

      // 13/4 -> Q=3 R=1, 7 edges, then holds while idle
      start_op(6'd13, 6'd4, 1'b0);
      wait_done(k, lows);
      chk("13/4_edges", 32'(k), 32'd7);
      chk("13/4_q", 32'(quociente), 32'd3);
      chk("13/4_r", 32'(resto), 32'd1);
      chk("13/4_dz", 32'(div_zero), 32'd0);
      dividendo = 6'd50;
      divisor   = 6'd7;
      repeat (4) @(negedge clk);
      chk("13/4_hold_q", 32'(quociente), 32'd3);
      chk("13/4_hold_r", 32'(resto), 32'd1);
      chk("13/4_hold_pronto", 32'(pronto), 32'd1);
      $display("op 13/4: q=%0d r=%0d edges=%0d", quociente, resto, k);

      // 3/5 -> Q=0 R=3 in 1 edge
      start_op(6'd3, 6'd5, 1'b0);
      wait_done(k, lows);
      chk("3/5_edges", 32'(k), 32'd1);
      chk("3/5_q", 32'(quociente), 32'd0);
      chk("3/5_r", 32'(resto), 32'd3);
      $display("op 3/5: q=%0d r=%0d edges=%0d", quociente, resto, k);

      // 0/7 -> Q=0 R=0 in 1 edge
      start_op(6'd0, 6'd7, 1'b0);
      wait_done(k, lows);
      chk("0/7_edges", 32'(k), 32'd1);
      chk("0/7_q", 32'(quociente), 32'd0);
      chk("0/7_r", 32'(resto), 32'd0);
      $display("op 0/7: q=%0d r=%0d edges=%0d", quociente, resto, k);

      // 63/1 worst case -> Q=63 R=0, 127 busy cycles with pronto low
      start_op(6'd63, 6'd1, 1'b0);
      wait_done(k, lows);
      chk("63/1_edges", 32'(k), 32'd127);
      chk("63/1_busy_low", 32'(lows), 32'd127);
      chk("63/1_q", 32'(quociente), 32'd63);
      chk("63/1_r", 32'(resto), 32'd0);
      $display("op 63/1: q=%0d r=%0d edges=%0d", quociente, resto, k);

      // 9/0 -> divide by zero, Q=63 R=9, 1 edge
      start_op(6'd9, 6'd0, 1'b0);
      wait_done(k, lows);
      chk("9/0_edges", 32'(k), 32'd1);
      chk("9/0_dz", 32'(div_zero), 32'd1);
      chk("9/0_q", 32'(quociente), 32'd63);
      chk("9/0_r", 32'(resto), 32'd9);
      $display("op 9/0: dz=%0b q=%0d r=%0d edges=%0d", div_zero, quociente, resto, k);

      // 6/3 clears the flag -> Q=2 R=0
      start_op(6'd6, 6'd3, 1'b0);
      wait_done(k, lows);
      chk("6/3_edges", 32'(k), 32'd5);
      chk("6/3_dz", 32'(div_zero), 32'd0);
      chk("6/3_q", 32'(quociente), 32'd2);
      chk("6/3_r", 32'(resto), 32'd0);
      $display("op 6/3: dz=%0b q=%0d r=%0d edges=%0d", div_zero, quociente, resto, k);

      // 40/3 with inputs toggled while busy -> Q=13 R=1, 27 edges
      start_op(6'd40, 6'd3, 1'b0);
      k = 0;
      while (pronto !== 1'b1 && k < LIMIT) begin
         inicio    = ~inicio;
         dividendo = 6'($urandom);
         divisor   = 6'($urandom);
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      inicio = 1'b0;
      chk("40/3_tog_edges", 32'(k), 32'd27);
      chk("40/3_tog_q", 32'(quociente), 32'd13);
      chk("40/3_tog_r", 32'(resto), 32'd1);
      $display("op 40/3 toggled: q=%0d r=%0d edges=%0d", quociente, resto, k);
      @(negedge clk);

      // 40/3 aborted by an asynchronous reset pulse at cycle 10
      start_op(6'd40, 6'd3, 1'b0);
      repeat (9) @(negedge clk);
      chk("abort_busy", 32'(pronto), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("abort_pronto", 32'(pronto), 32'd1);
      chk("abort_q", 32'(quociente), 32'd0);
      chk("abort_r", 32'(resto), 32'd0);
      chk("abort_dz", 32'(div_zero), 32'd0);
      chk("abort_state", 32'(dut.estado), 32'(IDLE));
      $display("op 40/3 reset: pronto=%0b q=%0d r=%0d", pronto, quociente, resto);

      // Release reset with inicio already high: 5/2 accepted on first edge
      inicio    = 1'b1;
      dividendo = 6'd5;
      divisor   = 6'd2;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_accepted", 32'(pronto), 32'd0);
      inicio = 1'b0;
      wait_done(k, lows);
      chk("5/2_edges", 32'(k), 32'd5);
      chk("5/2_q", 32'(quociente), 32'd2);
      chk("5/2_r", 32'(resto), 32'd1);
      $display("op 5/2 after reset: q=%0d r=%0d edges=%0d", quociente, resto, k);

      // Back-to-back with inicio held: 8/2 then 7/7
      start_op(6'd8, 6'd2, 1'b1);
      dividendo = 6'd7;
      divisor   = 6'd7;
      wait_done(k, lows);
      chk("8/2_edges", 32'(k), 32'd9);
      chk("8/2_q", 32'(quociente), 32'd4);
      chk("8/2_r", 32'(resto), 32'd0);
      chk("8/2_state_done", 32'(dut.estado), 32'(DONE));
      $display("op 8/2: q=%0d r=%0d edges=%0d", quociente, resto, k);
      @(negedge clk);
      chk("b2b_idle_pronto", 32'(pronto), 32'd1);
      chk("b2b_idle_q", 32'(quociente), 32'd4);
      @(negedge clk);
      chk("b2b_accept_2edges", 32'(pronto), 32'd0);
      inicio = 1'b0;
      wait_done(k, lows);
      chk("7/7_edges", 32'(k), 32'd3);
      chk("7/7_q", 32'(quociente), 32'd1);
      chk("7/7_r", 32'(resto), 32'd0);
      $display("op 7/7: q=%0d r=%0d edges=%0d", quociente, resto, k);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_maquina_estado_divisor
